keypad_emulator: RTL and testbench

Synthesizable model of a 4x4 matrix keypad: the responder side of the row-drive/column-sense keypad interface. It receives the active-high row drives R0-R3 from the keypad scanner and returns column senses C0-C3 exactly as a physical keypad would, including contact bounce on press and release. A host (test sequencer or on-chip self-test) queues one keypress at a time over a valid/ready handshake. It is used for hardware-in-loop self-test of the scanner, synchronizer and decoder chain without a physical keypad.

---
 rtl/keypad_emulator.sv | 191 +++++++++++++++++++
 tb/tb_keypad_emulator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
`timescale 1ns/1ps
// keypad_emulator: responder side of a 4x4 row-drive/column-sense keypad.
// Replays one host-queued keypress at a time, with contact chatter on press and release.
module keypad_emulator #(
  parameter int BOUNCE_PERIOD = 2,
  parameter int BOUNCE_PULSES = 2,
  parameter int MIN_GAP       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        R0,
  input  logic        R1,
  input  logic        R2,
  input  logic        R3,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] hold_len,
  output logic        key_ready,
  output logic        C0,
  output logic        C1,
  output logic        C2,
  output logic        C3,
  output logic        pressed,
  output logic        done,
  output logic [7:0]  press_count
);

  localparam int                 PULSE_W    = (BOUNCE_PULSES > 1) ? $clog2(BOUNCE_PULSES) : 1;
  localparam logic [15:0]        PHASE_LAST = 16'(BOUNCE_PERIOD - 1);
  localparam logic [15:0]        GAP_LAST   = 16'(MIN_GAP - 1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(BOUNCE_PULSES - 1);
  localparam bit                 HAS_BOUNCE = (BOUNCE_PULSES > 0);

  typedef enum logic [2:0] {
    IDLE,
    BOUNCE_PRESS,
    HELD,
    BOUNCE_RELEASE,
    GAP
  } state_t;

  state_t               state_q, state_d;
  logic                 contact_q, contact_d;
  logic [15:0]          phase_q, phase_d;
  logic [PULSE_W-1:0]   pulse_q, pulse_d;
  logic [15:0]          hold_q, hold_d;
  logic [3:0]           key_q, key_d;
  logic                 done_q, done_d;
  logic [7:0]           count_q, count_d;

  logic                 accept;
  logic                 phase_end;
  logic [3:0]           rows;
  logic                 row_hit;
  logic [3:0]           cols;

  assign key_ready = (state_q == IDLE);
  assign accept    = key_valid && key_ready;
  assign phase_end = (phase_q == PHASE_LAST);

  always_comb begin
    // NOTE: every next-state signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    contact_d = contact_q;
    phase_d   = phase_q;
    pulse_d   = pulse_q;
    hold_d    = hold_q;
    key_d     = key_q;
    done_d    = 1'b0;
    count_d   = count_q;

    unique case (state_q)
      IDLE: begin
        contact_d = 1'b0;
        if (accept) begin
          key_d     = key_code;
          hold_d    = (hold_len == 16'd0) ? 16'd1 : hold_len;
          phase_d   = '0;
          pulse_d   = '0;
          contact_d = 1'b1;
          if (HAS_BOUNCE) begin
            state_d = BOUNCE_PRESS;
          end else begin
            state_d = HELD;
            count_d = count_q + 8'd1;
          end
        end
      end

      // Closed half first; the open half of the last pulse hands over to HELD.
      BOUNCE_PRESS: begin
        if (!phase_end) begin
          phase_d = phase_q + 16'd1;
        end else begin
          phase_d = '0;
          if (contact_q) begin
            contact_d = 1'b0;
          end else if (pulse_q == PULSE_LAST) begin
            state_d   = HELD;
            contact_d = 1'b1;
            count_d   = count_q + 8'd1;
          end else begin
            pulse_d   = pulse_q + 1'b1;
            contact_d = 1'b1;
          end
        end
      end

      HELD: begin
        if (hold_q == 16'd1) begin
          contact_d = 1'b0;
          phase_d   = '0;
          pulse_d   = '0;
          state_d   = HAS_BOUNCE ? BOUNCE_RELEASE : GAP;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end

      // Open half first; the closed half of the last pulse hands over to GAP.
      BOUNCE_RELEASE: begin
        if (!phase_end) begin
          phase_d = phase_q + 16'd1;
        end else begin
          phase_d = '0;
          if (!contact_q) begin
            contact_d = 1'b1;
          end else if (pulse_q == PULSE_LAST) begin
            state_d   = GAP;
            contact_d = 1'b0;
          end else begin
            pulse_d   = pulse_q + 1'b1;
            contact_d = 1'b0;
          end
        end
      end

      GAP: begin
        contact_d = 1'b0;
        if (phase_q == GAP_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q + 16'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        contact_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      contact_q <= 1'b0;
      phase_q   <= '0;
      pulse_q   <= '0;
      hold_q    <= '0;
      key_q     <= '0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      contact_q <= contact_d;
      phase_q   <= phase_d;
      pulse_q   <= pulse_d;
      hold_q    <= hold_d;
      key_q     <= key_d;
      done_q    <= done_d;
      count_q   <= count_d;
    end
  end

  // Only the stored row can close a path, so at most one column is ever high.
  assign rows    = {R3, R2, R1, R0};
  assign row_hit = rows[key_q[3:2]];
  assign cols    = {4{contact_q & row_hit}} & (4'b0001 << key_q[1:0]);

  assign C0          = cols[0];
  assign C1          = cols[1];
  assign C2          = cols[2];
  assign C3          = cols[3];
  assign pressed     = contact_q;
  assign done        = done_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_keypad_emulator.sv
`timescale 1ns/1ps
// Bench for keypad_emulator: a bouncing instance and a clean-edge instance, each compared
// every cycle against a timeline model (contact as a function of cycles since accept).
module tb_keypad_emulator;

  localparam int BNC_T   = 2;
  localparam int BNC_P   = 2;
  localparam int CLN_T   = 1;
  localparam int CLN_P   = 0;
  localparam int GAP_CYC = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  rows;
  logic        kv  [2];
  logic [3:0]  kc  [2];
  logic [15:0] hl  [2];
  logic        rdy [2];
  logic        pr  [2];
  logic        dn  [2];
  logic [3:0]  col [2];
  logic [7:0]  pc  [2];

  int n_checks = 0;
  int n_err    = 0;

  keypad_emulator #(.BOUNCE_PERIOD(BNC_T), .BOUNCE_PULSES(BNC_P), .MIN_GAP(GAP_CYC)) u_bnc (
    .clk(clk), .reset(rst_n),
    .R0(rows[0]), .R1(rows[1]), .R2(rows[2]), .R3(rows[3]),
    .key_valid(kv[0]), .key_code(kc[0]), .hold_len(hl[0]),
    .key_ready(rdy[0]),
    .C0(col[0][0]), .C1(col[0][1]), .C2(col[0][2]), .C3(col[0][3]),
    .pressed(pr[0]), .done(dn[0]), .press_count(pc[0])
  );

  keypad_emulator #(.BOUNCE_PERIOD(CLN_T), .BOUNCE_PULSES(CLN_P), .MIN_GAP(GAP_CYC)) u_cln (
    .clk(clk), .reset(rst_n),
    .R0(rows[0]), .R1(rows[1]), .R2(rows[2]), .R3(rows[3]),
    .key_valid(kv[1]), .key_code(kc[1]), .hold_len(hl[1]),
    .key_ready(rdy[1]),
    .C0(col[1][0]), .C1(col[1][1]), .C2(col[1][2]), .C3(col[1][3]),
    .pressed(pr[1]), .done(dn[1]), .press_count(pc[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  bit         m_idle [2];
  int         m_t    [2];
  logic [3:0] m_key  [2];
  int         m_hold [2];
  logic [7:0] m_cnt  [2];
  bit         m_done [2];

  function automatic int p_of(input int i);
    return (i == 0) ? BNC_P : CLN_P;
  endfunction

  function automatic int t_of(input int i);
    return (i == 0) ? BNC_T : CLN_T;
  endfunction

  function automatic int seq_len(input int i);
    return 4 * p_of(i) * t_of(i) + m_hold[i] + GAP_CYC;
  endfunction

  // Contact level in cycle t (1 = first cycle after accept).
  function automatic bit exp_contact(input int i);
    int b;
    int t;
    int h;
    b = 2 * p_of(i) * t_of(i);
    t = m_t[i];
    h = m_hold[i];
    if (m_idle[i])       return 1'b0;
    if (t <= b)          return ((t - 1) / t_of(i)) % 2 == 0;
    if (t <= b + h)      return 1'b1;
    if (t <= 2 * b + h)  return ((t - b - h - 1) / t_of(i)) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic logic [14:0] exp_vec(input int i);
    bit         c;
    logic [3:0] cv;
    c  = exp_contact(i);
    cv = '0;
    if (c && rows[m_key[i][3:2]]) cv[m_key[i][1:0]] = 1'b1;
    return {m_idle[i], cv, c, m_done[i], m_cnt[i]};
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_idle[i] = 1'b1; m_t[i] = 0; m_key[i] = '0; m_hold[i] = 1; m_cnt[i] = '0; m_done[i] = 1'b0;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          m_idle[i] = 1'b1; m_t[i] = 0; m_key[i] = '0; m_hold[i] = 1; m_cnt[i] = '0; m_done[i] = 1'b0;
        end else begin
          m_done[i] = 1'b0;
          if (m_idle[i]) begin
            if (kv[i]) begin
              m_idle[i] = 1'b0;
              m_t[i]    = 1;
              m_key[i]  = kc[i];
              m_hold[i] = (hl[i] == 16'd0) ? 1 : int'(hl[i]);
            end
          end else if (m_t[i] == seq_len(i)) begin
            m_idle[i] = 1'b1;
            m_done[i] = 1'b1;
            m_t[i]    = 0;
          end else begin
            m_t[i]++;
          end
          if (!m_idle[i] && m_t[i] == 2 * p_of(i) * t_of(i) + 1) m_cnt[i] = m_cnt[i] + 8'd1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("cycle_u%0d{rdy,C,pr,done,cnt}", i),
              32'({rdy[i], col[i], pr[i], dn[i], pc[i]}), 32'(exp_vec(i)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ready(input int i);
    int n;
    n = 0;
    while (!rdy[i] && n < 300) begin
      tick();
      n++;
    end
    check($sformatf("ready_u%0d", i), 32'(rdy[i]), 32'd1);
  endtask

  // Returns in the first cycle after the accepting edge; inputs are scrambled afterwards.
  task automatic send(input int i, input logic [3:0] code, input logic [15:0] h);
    wait_ready(i);
    kv[i] = 1'b1;
    kc[i] = code;
    hl[i] = h;
    tick();
    kv[i] = 1'b0;
    kc[i] = 4'($urandom);
    hl[i] = 16'($urandom);
  endtask

  initial begin : stim
    int          ones;
    int          other;
    int          ready_at;
    int          dones;
    int          n;
    logic [23:0] c0_seq;

    rows  = '0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      kv[i] = 1'b0; kc[i] = '0; hl[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_bnc", 32'(rdy[0]), 32'd1);
    check("reset_cols_bnc", 32'(col[0]), 32'd0);
    #1;
    rst_n = 1'b1;
    tick();

    // Clean press: C2 for exactly 10 cycles, ready again in cycle 14 (13 edges after accept).
    rows = 4'b0010;
    send(1, 4'b0110, 16'd10);
    ones = 0; other = 0; ready_at = 0; dones = 0;
    for (int k = 1; k <= 20; k++) begin
      if (k <= 10) check($sformatf("clean_c2_k%0d", k), 32'(col[1][2]), 32'd1);
      if (col[1][2]) ones++;
      if (col[1][0] | col[1][1] | col[1][3]) other++;
      if (rdy[1] && ready_at == 0) ready_at = k;
      if (dn[1]) dones++;
      tick();
    end
    check("clean_c2_total", 32'(ones), 32'd10);
    check("clean_other_cols", 32'(other), 32'd0);
    check("clean_ready_cycle", 32'(ready_at), 32'd14);
    check("clean_done_pulses", 32'(dones), 32'd1);
    check("clean_press_count", 32'(pc[1]), 32'd1);

    // Bounce timeline on C0.
    rows = 4'b0001;
    send(0, 4'b0000, 16'd5);
    for (int k = 1; k <= 24; k++) begin
      c0_seq[24 - k] = col[0][0];
      tick();
    end
    check("bounce_c0_seq", 32'(c0_seq), 32'(24'b11001100_11111_00110011_000));
    check("bounce_end_ready_done", 32'({rdy[0], dn[0]}), 32'b11);

    // Row gating: key 1011 is row 2, column 3.
    rows = 4'b0000;
    send(0, 4'b1011, 16'd40);
    repeat (8) tick();
    for (int r = 0; r < 4; r++) begin
      rows = 4'b0001 << r;
      #1;
      check($sformatf("gate_row%0d", r), 32'(col[0]), (r == 2) ? 32'h8 : 32'h0);
      tick();
    end
    rows = 4'b1111;
    #1;
    check("gate_all_rows", 32'(col[0]), 32'h8);
    rows = 4'b1011;
    #1;
    check("gate_drop_same_cycle", 32'(col[0]), 32'h0);
    tick();
    wait_ready(0);

    // Busy rejection, then back-to-back accept on the done cycle.
    rows = 4'b0011;
    send(0, 4'b0000, 16'd5);
    repeat (9) tick();
    kv[0] = 1'b1; kc[0] = 4'b0101; hl[0] = 16'd3;
    n = 0;
    while (!rdy[0] && n < 100) begin
      tick();
      n++;
    end
    check("busy_wait_cycles", 32'(n), 32'd15);
    check("busy_done_cycle", 32'({rdy[0], dn[0]}), 32'b11);
    tick();
    kv[0] = 1'b0;
    check("b2b_started", 32'({rdy[0], pr[0], col[0]}), 32'b0_1_0010);
    wait_ready(0);

    // Reset in the middle of HELD.
    rows = 4'b0001;
    send(0, 4'b0000, 16'd20);
    repeat (10) tick();
    check("midheld_c0", 32'(col[0]), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({rdy[0], col[0], pr[0], dn[0], pc[0]}), 32'h4000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 256 single-cycle presses on the clean instance.
    for (int j = 0; j < 256; j++) begin
      rows = 4'($urandom);
      send(1, 4'($urandom), 16'd0);
      check("zero_hold_pressed", 32'(pr[1]), 32'd1);
      if (j == 254) check("count_255", 32'(pc[1]), 32'd255);
      if (j == 255) check("count_wrap", 32'(pc[1]), 32'd0);
      tick();
      check("zero_hold_released", 32'(pr[1]), 32'd0);
    end

    // Random traffic on both instances, with one asynchronous reset inside it.
    for (int k = 0; k < 2000; k++) begin
      rows = 4'($urandom);
      for (int i = 0; i < 2; i++) begin
        kv[i] = ($urandom_range(0, 3) == 0);
        kc[i] = 4'($urandom);
        hl[i] = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 6));
      end
      if (k == 1000) begin
        #1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end
    kv[0] = 1'b0;
    kv[1] = 1'b0;
    repeat (60) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
